// File: rtl/osd_wb_slave_sram.sv
// rtl/osd_wb_slave_sram.sv - Wishbone B3 slave with word-addressed SRAM and programmable ack latency
// Classic and linear incrementing bursts are served beat by beat; every beat decodes its own address.
module osd_wb_slave_sram #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int BASE_ADDR   = 0,
    parameter int ACK_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    ack_o,
    output logic                    err_o
);

    localparam int SW  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(SW);
    localparam int IW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW  = (ACK_LATENCY > 1) ? $clog2(ACK_LATENCY) : 1;
    localparam logic [CW-1:0]         CNT_INIT   = CW'((ACK_LATENCY > 1) ? (ACK_LATENCY - 2) : 0);
    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SW - 1);
    localparam logic [ADDR_WIDTH-1:0] WORDS      = ADDR_WIDTH'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CW-1:0]           cnt;
    logic                    resp_err;
    logic                    beat_req;
    logic                    enter_resp;
    logic                    bad;
    logic [ADDR_WIDTH-1:0]   off;
    logic [ADDR_WIDTH-1:0]   idx_full;
    logic [IW-1:0]           idx;
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

    assign beat_req = cyc_i & stb_i;
    assign off      = addr_i - BASE;
    assign idx_full = off >> LSB;
    assign idx      = idx_full[IW-1:0];
    assign bad      = ((off & ALIGN_MASK) != '0) || (idx_full >= WORDS) || (addr_i < BASE) ||
                      ((cti_i == 3'b010) && (bte_i != 2'b00));
    // All side effects of a beat happen on the single edge that enters RESP.
    assign enter_resp = (next_state == RESP) && (state != RESP) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            resp_err <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == WAIT)
                cnt <= CNT_INIT;
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (enter_resp)
                resp_err <= bad;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (beat_req) next_state = (ACK_LATENCY == 1) ? RESP : WAIT;
            WAIT: begin
                if (!beat_req)
                    next_state = IDLE;
                else if (cnt == '0)
                    next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ack_o = (state == RESP) && !resp_err;
        err_o = (state == RESP) && resp_err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            dat_o <= '0;
        else if (enter_resp && !bad && !we_i)
            dat_o <= mem[idx];
    end

    // SRAM is deliberately left out of reset so debug scratch contents survive it.
    always_ff @(posedge clk_i) begin
        if (enter_resp && !bad && we_i) begin
            for (int b = 0; b < SW; b++) begin
                if (sel_i[b])
                    mem[idx][8*b +: 8] <= dat_i[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_osd_wb_slave_sram.sv
// tb/tb_osd_wb_slave_sram.sv - self-checking bench for osd_wb_slave_sram at ack latencies 1 and 3
module tb_osd_wb_slave_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] dat = '0;
    logic [1:0]  sel = '0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    int          dsel = 0;

    logic        cyc1, stb1, cyc3, stb3;
    logic [15:0] dat_o1, dat_o3, dat_m;
    logic        ack1, err1, ack3, err3, ack_m, err_m;

    int errors = 0;
    int checks = 0;

    logic [15:0] mdl     [2][1024];
    bit          known   [2][1024];
    logic [15:0] last_rd [2];
    bit          last_ok [2];

    always #5 clk = ~clk;

    assign cyc1  = cyc && (dsel == 0);
    assign stb1  = stb && (dsel == 0);
    assign cyc3  = cyc && (dsel == 1);
    assign stb3  = stb && (dsel == 1);
    assign ack_m = (dsel == 0) ? ack1 : ack3;
    assign err_m = (dsel == 0) ? err1 : err3;
    assign dat_m = (dsel == 0) ? dat_o1 : dat_o3;

    osd_wb_slave_sram #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .MEM_WORDS(1024), .BASE_ADDR(0), .ACK_LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc1), .stb_i(stb1), .we_i(we), .addr_i(addr),
        .dat_i(dat), .sel_i(sel), .cti_i(cti), .bte_i(bte), .dat_o(dat_o1), .ack_o(ack1), .err_o(err1));

    osd_wb_slave_sram #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .MEM_WORDS(1024), .BASE_ADDR(0), .ACK_LATENCY(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc3), .stb_i(stb3), .we_i(we), .addr_i(addr),
        .dat_i(dat), .sel_i(sel), .cti_i(cti), .bte_i(bte), .dat_o(dat_o3), .ack_o(ack3), .err_o(err3));

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [15:0] wd;
        logic [1:0]  s;
        logic [2:0]  ct;
        logic [1:0]  bt;
        bit          e_err;
        logic [15:0] e_dat;
        bit          chk_dat;
    } vec_t;

    vec_t tbl[12];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit exp_error(input logic [31:0] a, input logic [2:0] ct, input logic [1:0] bt);
        return (a % 2 != 0) || (a / 2 >= 1024) || (ct == 3'b010 && bt != 2'b00);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Runs one beat starting just after a negedge; returns at a negedge.
    task automatic beat(input int d, input bit w, input logic [31:0] a, input logic [15:0] wd,
                        input logic [1:0] s, input logic [2:0] ct, input logic [1:0] bt,
                        input bit hold, input int exp_lat, output bit r_err, output logic [15:0] r_dat);
        int n = 0;
        bit e;
        int idx;
        dsel = d; we = w; addr = a; dat = wd; sel = s; cti = ct; bte = bt; cyc = 1'b1; stb = 1'b1;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!(ack_m || err_m) && n < 30);
        r_err = err_m;
        r_dat = dat_m;
        if (n >= 30) begin
            chk("beat_timeout", 32'(n), 32'(exp_lat));
            cyc = 1'b0; stb = 1'b0;
            return;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        e = exp_error(a, ct, bt);
        chk("resp_err", {30'd0, err_m, ack_m}, {30'd0, e, !e});
        idx = int'(a / 2);
        if (!e && w) begin
            for (int b = 0; b < 2; b++)
                if (s[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
            known[d][idx] = known[d][idx] || (s == 2'b11);
        end
        if (!e && !w) begin
            if (known[d][idx]) begin
                chk("rd_data", {16'd0, dat_m}, {16'd0, mdl[d][idx]});
                last_rd[d] = mdl[d][idx];
                last_ok[d] = 1'b1;
            end else begin
                last_ok[d] = 1'b0;
            end
        end else if (last_ok[d]) begin
            chk("dat_hold", {16'd0, dat_m}, {16'd0, last_rd[d]});
        end
        if (!hold) begin
            cyc = 1'b0; stb = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("single_pulse", {30'd0, ack_m, err_m}, 32'd0);
        end
    endtask

    initial begin
        bit          r_err;
        logic [15:0] r_dat;

        tbl[0]  = '{1'b1, 32'h10,  16'h1234, 2'b11, 3'b000, 2'b00, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h10,  16'h0000, 2'b11, 3'b000, 2'b00, 1'b0, 16'h1234, 1'b1};
        tbl[2]  = '{1'b1, 32'h20,  16'hAAAA, 2'b11, 3'b111, 2'b00, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 32'h20,  16'h5566, 2'b01, 3'b000, 2'b00, 1'b0, 16'h0000, 1'b0};
        tbl[4]  = '{1'b0, 32'h20,  16'h0000, 2'b11, 3'b000, 2'b00, 1'b0, 16'hAA66, 1'b1};
        tbl[5]  = '{1'b1, 32'h11,  16'h7777, 2'b11, 3'b000, 2'b00, 1'b1, 16'h0000, 1'b0};
        tbl[6]  = '{1'b1, 32'h800, 16'h7777, 2'b11, 3'b000, 2'b00, 1'b1, 16'h0000, 1'b0};
        tbl[7]  = '{1'b1, 32'h10,  16'h9999, 2'b11, 3'b010, 2'b01, 1'b1, 16'h0000, 1'b0};
        tbl[8]  = '{1'b0, 32'h10,  16'h0000, 2'b11, 3'b000, 2'b00, 1'b0, 16'h1234, 1'b1};
        tbl[9]  = '{1'b0, 32'h11,  16'h0000, 2'b11, 3'b000, 2'b00, 1'b1, 16'h1234, 1'b1};
        tbl[10] = '{1'b1, 32'h20,  16'hFFFF, 2'b00, 3'b000, 2'b00, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{1'b0, 32'h20,  16'h0000, 2'b11, 3'b010, 2'b00, 1'b0, 16'hAA66, 1'b1};

        for (int d = 0; d < 2; d++) begin
            last_rd[d] = '0;
            last_ok[d] = 1'b1;
            for (int i = 0; i < 1024; i++) known[d][i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk("reset_outputs", {dat_o1, 12'd0, ack1, err1, ack3, err3}, 32'd0);
        chk("reset_dat3", {16'd0, dat_o3}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 12; i++) begin
                beat(d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].s, tbl[i].ct, tbl[i].bt, 1'b0,
                     lat_of(d), r_err, r_dat);
                chk("tbl_err", {31'd0, r_err}, {31'd0, tbl[i].e_err});
                if (tbl[i].chk_dat) chk("tbl_dat", {16'd0, r_dat}, {16'd0, tbl[i].e_dat});
            end

        // Abort during WAIT on the latency-3 slave.
        dsel = 1; we = 1'b1; addr = 32'h10; dat = 16'hDEAD; sel = 2'b11; cti = 3'b000; bte = 2'b00;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_noresp", {30'd0, ack3, err3}, 32'd0);
        end
        beat(1, 1'b0, 32'h10, 16'h0, 2'b11, 3'b000, 2'b00, 1'b0, 3, r_err, r_dat);
        chk("abort_nowrite", {16'd0, r_dat}, 32'h1234);

        // Reset while a write waits.
        dsel = 1; we = 1'b1; addr = 32'h10; dat = 16'hBEEF; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0; last_ok[0] = 1'b1; last_ok[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_noresp", {30'd0, ack3, err3}, 32'd0);
        end
        beat(1, 1'b0, 32'h10, 16'h0, 2'b11, 3'b000, 2'b00, 1'b0, 3, r_err, r_dat);
        chk("rst_nowrite", {16'd0, r_dat}, 32'h1234);

        // Linear bursts with stb held: first beat LAT, then LAT+1 spacing.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++)
                beat(d, 1'b1, 32'h40 + 32'(2*k), 16'(k + 1), 2'b11, (k < 3) ? 3'b010 : 3'b111, 2'b00,
                     k < 3, (k == 0) ? lat_of(d) : lat_of(d) + 1, r_err, r_dat);
            for (int k = 0; k < 4; k++) begin
                beat(d, 1'b0, 32'h40 + 32'(2*k), 16'h0, 2'b11, 3'b000, 2'b00, 1'b0, lat_of(d), r_err, r_dat);
                chk("burst_rd", {16'd0, r_dat}, 32'(k + 1));
            end
        end

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 32; w++)
                beat(d, 1'b1, 32'(2*w), 16'($urandom), 2'b11, 3'b000, 2'b00, 1'b0, lat_of(d), r_err, r_dat);

        for (int i = 0; i < 300; i++) begin
            int          d;
            int          r;
            logic [31:0] a;
            logic [2:0]  ct;
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 19));
            if (r == 0)      a = 32'(2 * $urandom_range(0, 31) + 1);
            else if (r == 1) a = 32'h800 + 32'(2 * $urandom_range(0, 15));
            else             a = 32'(2 * $urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0:       ct = 3'b000;
                1:       ct = 3'b010;
                default: ct = 3'b111;
            endcase
            beat(d, 1'($urandom), a, 16'($urandom), 2'($urandom), ct,
                 ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00, 1'b0, lat_of(d), r_err, r_dat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
